univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
Parametrised universal register: a WIDTH-bit bank of D flip-flops with complemented outputs, serial in/out at both ends, and eight operating modes (hold, shift, rotate, load, clear, set). A burst controller runs an N-step shift or rotate autonomously, reporting busy and a one-cycle done. It is the general-purpose storage and serialiser element for datapath and SPI-style serial blocks.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst length field; max burst = 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  clock enable; gates every register update except reset
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin_l  input  1  serial in, enters at LSB on shift left
sin_r  input  1  serial in, enters at MSB on shift right
burst_start  input  1  request burst of burst_len steps of the current mode
burst_len  input  CNT_W  burst step count
q  output  WIDTH  register contents
qb  output  WIDTH  bitwise complement of q
sout_l  output  1  q[WIDTH-1]
sout_r  output  1  q[0]
busy  output  1  burst in progress
done  output  1  one-cycle pulse after final burst step

Behaviour:
- Reset (async, any time, incl. mid-burst): q=0, qb=all ones, sout_l=0, sout_r=0, busy=0, done=0, FSM=IDLE, counter=0, latched mode=000.
- qb, sout_l and sout_r are combinational from q; they never disagree with q in any cycle.
- Mode codes, applied on the rising edge when en=1:
  - 000: hold.
  - 001: shift right, q<={sin_r,q[W-1:1]}.
  - 010: shift left, q<={q[W-2:0],sin_l}.
  - 011: load, q<=d.
  - 100: rotate right, q<={q[0],q[W-1:1]}.
  - 101: rotate left, q<={q[W-2:0],q[W-1]}.
  - 110: clear, q<=0.
  - 111: set, q<=all ones.
- en=0: q holds in every state; the counter holds; burst state holds.
- FSM states:
  - IDLE: single-step operation per mode.
  - RUN: autonomous burst.
- IDLE -> RUN when burst_start=1, en=1, burst_len!=0 and mode is in {001,010,100,101}.
  - Captures mode into the latched mode and burst_len into the counter.
  - Sets busy=1.
  - The start cycle performs NO data operation; q holds.
- burst_start with burst_len=0 or a non-shift/rotate mode: the request is ignored, no busy and no done; the normal single-step op for that mode executes.
- RUN, each edge with en=1: apply the latched op and decrement the counter.
  - When the counter was 1: go to IDLE, busy<=0, done<=1.
- Result: with en held high, busy is high for exactly N cycles and done is high for exactly one cycle, the cycle in which busy first reads 0.
- In RUN, the mode, d, burst_start and burst_len inputs are ignored; sin_l and sin_r are still sampled each step.
- done is cleared on the next edge regardless of en. A new burst_start is accepted in the same cycle that done is high; the new burst's start edge clears done.
- The counter never wraps: there is no decrement in IDLE or from 0.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle -> q=0x00 and qb=0xFF immediately, busy=0, done=0; release, mode=000 for 3 cycles -> q stays 0x00.
- Load and modes: load d=0xA5 (mode=011), then mode 100 once -> q=0xD2; mode 101 once -> 0xA5; mode 110 -> 0x00; mode 111 -> 0xFF with qb=0x00; en=0 with mode=011 -> q unchanged.
- Serial shift: q=0x00, mode=010 with sin_l=1,0,1,1 over four edges -> q=0x0B, sout_l=0; mode=001 with sin_r=1 once -> q=0x85, sout_r=1.
- Burst rotate: q=0x81, burst_start with mode=101, burst_len=3 -> busy high 3 cycles, q goes 0x03, 0x06, 0x0C; done pulses once; mode/d changes during RUN have no effect.
- Burst stall and ignored requests: burst of 4 right shifts with en dropped for 2 cycles mid-burst -> busy high 6 cycles, exactly 4 shifts. burst_start with burst_len=0 or mode=011 -> busy stays 0 and no done.
- Reset mid-burst: rst during a burst of 7 at step 3 -> q=0, busy=0, done never pulses; a new burst after reset completes normally.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   WIDTH-bit universal register with complemented outputs, serial in/out at
//   both ends, and eight operating modes. A burst controller runs an N-step
//   shift or rotate on its own, with busy high during the burst and a
//   one-cycle done after the final step.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           clock enable for every update except reset (and done clear)
//   mode         000 hold, 001 shr, 010 shl, 011 load, 100 ror, 101 rol,
//                110 clear, 111 set
//   d            parallel load data
//   sin_l        serial in at LSB on shift left
//   sin_r        serial in at MSB on shift right
//   burst_start  request a burst of burst_len steps of the current mode
//   burst_len    burst step count
//   q, qb        register contents and its complement
//   sout_l       q[WIDTH-1]
//   sout_r       q[0]
//   busy         burst in progress
//   done         one-cycle pulse after the final burst step
//
// state | meaning
// IDLE  | single-step operation per mode, burst requests accepted
// RUN   | autonomous burst using the latched mode
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_lat_q, mode_lat_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             start_ok;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      3'b001:  r = {sr, cur[WIDTH-1:1]};
      3'b010:  r = {cur[WIDTH-2:0], sl};
      3'b011:  r = din;
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  r = '0;
      3'b111:  r = '1;
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only shift/rotate modes with a nonzero length start a burst.
  assign start_ok = burst_start && (burst_len != '0) &&
                    (mode == 3'b001 || mode == 3'b010 ||
                     mode == 3'b100 || mode == 3'b101);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_lat_q <= 3'b000;
      q_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_lat_q <= mode_lat_d;
      q_q        <= q_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_lat_d = mode_lat_q;
    q_d        = q_q;
    done_d     = 1'b0;  // done lasts one cycle even while en is low
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            // Start edge only captures the burst; data holds this cycle.
            state_d    = RUN;
            cnt_d      = burst_len;
            mode_lat_d = mode;
          end else begin
            q_d = apply_op(mode, q_q, d, sin_l, sin_r);
          end
        end
        RUN: begin
          q_d = apply_op(mode_lat_q, q_q, d, sin_l, sin_r);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign q      = q_q;
  assign qb     = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule
